// File: rtl/encoder_pkg.sv
// Shared constants and FSM state type for the 8:3 scanning encoder.
package encoder_pkg;
    localparam int N_IN  = 8;
    localparam int W_IDX = 3;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;
endpackage

// File: rtl/prio_enc8.sv
// Combinational 8-bit priority selector with a one-bit-left flag.
module prio_enc8
    import encoder_pkg::*;
#(
    parameter bit HIGH_FIRST = 1'b1
) (
    input  logic [N_IN-1:0]  vec,
    output logic [W_IDX-1:0] idx,
    output logic             one_left
);

    always_comb begin
        idx = '0;
        if (HIGH_FIRST) begin
            for (int k = 0; k < N_IN; k++)
                if (vec[k]) idx = W_IDX'(k);
        end else begin
            for (int k = N_IN - 1; k >= 0; k--)
                if (vec[k]) idx = W_IDX'(k);
        end
    end

    // Clearing the lowest set bit leaves zero only for a single-bit vector.
    assign one_left = (vec != '0) &&
                      ((vec & (vec - N_IN'(1))) == '0);

endmodule

// File: rtl/encoder83_scan.sv
// Accepts a request vector and reports its set bits one beat at a time.
module encoder83_scan
    import encoder_pkg::*;
#(
    parameter bit HIGH_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N_IN-1:0]  i,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W_IDX-1:0] y,
    output logic             last,
    output logic             zero
);

    state_t            state, state_nxt;
    logic [N_IN-1:0]   pend, pend_nxt;
    logic              zero_r, zero_nxt;
    logic [W_IDX-1:0]  idx;
    logic              one_left;
    logic              beat_last;
    logic [N_IN-1:0]   hot;

    prio_enc8 #(
        .HIGH_FIRST(HIGH_FIRST)
    ) u_prio (
        .vec     (pend),
        .idx     (idx),
        .one_left(one_left)
    );

    assign beat_last = zero_r | one_left;

    always_comb begin
        hot      = '0;
        hot[idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            pend   <= '0;
            zero_r <= 1'b0;
        end else begin
            state  <= state_nxt;
            pend   <= pend_nxt;
            zero_r <= zero_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pend_nxt  = pend;
        zero_nxt  = zero_r;
        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    pend_nxt  = i;
                    zero_nxt  = (i == '0);
                    state_nxt = SCAN;
                end
            end
            SCAN: begin
                if (out_ready) begin
                    pend_nxt = pend & ~hot;
                    if (beat_last) state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are gated by state so IDLE always shows all-zero beats.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == SCAN);
    assign y         = (state == SCAN && !zero_r) ? idx : '0;
    assign last      = (state == SCAN) && beat_last;
    assign zero      = (state == SCAN) && zero_r;

endmodule

// File: tb/tb_encoder83_scan.sv
// Randomized bench for encoder83_scan, both scan directions side by side.
module tb_encoder83_scan;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] i = 8'h00;
    logic       out_ready = 1'b0;

    logic       in_ready_h, out_valid_h, last_h, zero_h;
    logic [2:0] y_h;
    logic       in_ready_l, out_valid_l, last_l, zero_l;
    logic [2:0] y_l;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    encoder83_scan #(.HIGH_FIRST(1'b1)) u_hi (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready_h),
        .i(i), .out_valid(out_valid_h),
        .out_ready(out_ready), .y(y_h),
        .last(last_h), .zero(zero_h)
    );

    encoder83_scan #(.HIGH_FIRST(1'b0)) u_lo (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready_l),
        .i(i), .out_valid(out_valid_l),
        .out_ready(out_ready), .y(y_l),
        .last(last_l), .zero(zero_l)
    );

    task automatic chk(input string tag,
                       input logic [7:0] got,
                       input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h (t=%0t)",
                     tag, got, exp, $time);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_rdy_h"}, {7'd0, in_ready_h}, 8'd1);
        chk({tag, "_rdy_l"}, {7'd0, in_ready_l}, 8'd1);
        chk({tag, "_vld_h"}, {7'd0, out_valid_h}, 8'd0);
        chk({tag, "_vld_l"}, {7'd0, out_valid_l}, 8'd0);
    endtask

    // Drives one vector and checks every beat against a list model.
    // mode: 0 ready always, 1 random stalls, 2 ready every third cycle.
    task automatic run_vec(input logic [7:0] v, input int mode,
                           input bit noise, input bit no_sync);
        int hi_q[$];
        int lo_q[$];
        int n, k, stall;
        bit rdy;
        for (int b = 7; b >= 0; b--) if (v[b]) hi_q.push_back(b);
        for (int b = 0; b < 8; b++) if (v[b]) lo_q.push_back(b);
        if (v == 8'h00) begin
            hi_q.push_back(0);
            lo_q.push_back(0);
        end
        n = hi_q.size();
        if (!no_sync) @(negedge clk);
        chk_idle("acc");
        in_valid = 1'b1;
        i = v;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        k = 0;
        stall = 0;
        while (k < n) begin
            @(negedge clk);
            chk("vld_h", {7'd0, out_valid_h}, 8'd1);
            chk("vld_l", {7'd0, out_valid_l}, 8'd1);
            chk("busy_h", {7'd0, in_ready_h}, 8'd0);
            chk("busy_l", {7'd0, in_ready_l}, 8'd0);
            chk("y_h", {5'd0, y_h}, 8'(hi_q[k]));
            chk("y_l", {5'd0, y_l}, 8'(lo_q[k]));
            chk("last_h", {7'd0, last_h}, 8'(k == n - 1));
            chk("last_l", {7'd0, last_l}, 8'(k == n - 1));
            chk("zero_h", {7'd0, zero_h}, 8'(v == 8'h00));
            chk("zero_l", {7'd0, zero_l}, 8'(v == 8'h00));
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (stall >= 3) ? 1'b1 : 1'($urandom % 2);
                default: rdy = (cyc % 3 == 0);
            endcase
            out_ready = rdy;
            if (noise) begin
                in_valid = 1'($urandom % 2);
                i = 8'($urandom);
            end
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            if (rdy) begin
                k++;
                stall = 0;
            end else begin
                stall++;
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk_idle("rst");
        chk("rst_y_h", {5'd0, y_h}, 8'd0);
        chk("rst_last_h", {7'd0, last_h}, 8'd0);
        chk("rst_zero_h", {7'd0, zero_h}, 8'd0);
        rst_n = 1'b1;

        run_vec(8'b0000_0001, 0, 1'b0, 1'b1);
        run_vec(8'b1010_0100, 0, 1'b0, 1'b0);
        run_vec(8'h00, 0, 1'b0, 1'b0);
        run_vec(8'hFF, 2, 1'b1, 1'b0);
        run_vec(8'h81, 1, 1'b1, 1'b0);

        // Reset lands mid-scan after two of five beats.
        @(negedge clk);
        in_valid = 1'b1;
        i = 8'h1F;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        chk("pre_rst_vld", {7'd0, out_valid_h}, 8'd1);
        chk("pre_rst_y_h", {5'd0, y_h}, 8'd2);
        chk("pre_rst_y_l", {5'd0, y_l}, 8'd2);
        rst_n = 1'b0;
        #1;
        chk_idle("arst");
        chk("arst_y_h", {5'd0, y_h}, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk_idle("post_rst");
        end
        run_vec(8'h10, 0, 1'b0, 1'b1);

        for (int v = 0; v < 256; v++)
            run_vec(8'(v), 1, 1'b1, 1'b0);

        @(negedge clk);
        chk_idle("end");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/encoder83_scan.md
ENCODER83_SCAN -- requirements
Module: encoder83_scan

Interface
REQ-001 The block SHALL have parameter HIGH_FIRST, default 1, meaning 1 = report highest set bit first and 0 = report lowest set bit first.
REQ-002 Port clk  input  1  rising-edge clock for all state.
REQ-003 Port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 Port in_valid  input  1  i holds a one-hot or multi-hot request vector to encode.
REQ-005 Port in_ready  output  1  block can accept a new vector.
REQ-006 Port i  input  8  request vector; bit k set means index k is present.
REQ-007 Port out_valid  output  1  y, last and zero are valid.
REQ-008 Port out_ready  input  1  consumer accepts the current output beat.
REQ-009 Port y  output  3  encoded index of the bit currently reported.
REQ-010 Port last  output  1  current beat is the final beat for the accepted vector.
REQ-011 Port zero  output  1  the accepted vector was all zeros; no index is present.

Function
REQ-012 The block SHALL implement an FSM with states IDLE and SCAN, and SHALL handle one vector at a time.
REQ-013 In IDLE, in_ready SHALL be 1 and out_valid SHALL be 0.
REQ-014 In IDLE, when in_valid=1, the block SHALL capture i into an 8-bit pending register pend, capture zero_r=(i==0), and move to SCAN on the same edge.
REQ-015 In SCAN, in_ready SHALL be 0, out_valid SHALL be 1, and in_valid/i SHALL be ignored.
REQ-016 Latency: the first out_valid SHALL appear exactly 1 cycle after the accept edge.
REQ-017 In SCAN with pend!=0, y SHALL be the index of the highest set bit of pend when HIGH_FIRST=1, or the lowest set bit when HIGH_FIRST=0.
REQ-018 In SCAN with pend!=0, last SHALL be 1 exactly when pend has one bit set, and zero SHALL be 0.
REQ-019 In SCAN with zero_r=1, the block SHALL present a single beat with y=0, last=1, zero=1.
REQ-020 The beat SHALL complete on a clock edge with out_valid=1 and out_ready=1; the reported bit SHALL then be cleared from pend.
REQ-021 When the completed beat has last=1, the FSM SHALL return to IDLE.
REQ-022 While out_ready=0, y, last, zero and pend SHALL hold stable; there SHALL be no beat drop or duplication.
REQ-023 Throughput: with out_ready held at 1, a vector with n set bits SHALL take n beats on n consecutive cycles, plus 1 IDLE cycle before the next accept.
REQ-024 Outputs SHALL derive only from registered state (pend, zero_r, FSM); there SHALL be no combinational path from i, in_valid or out_ready to any output.
REQ-025 The number of beats emitted for an accepted vector SHALL equal popcount(i), or 1 if i==0.

Reset
REQ-026 When rst_n=0, the block SHALL asynchronously force FSM=IDLE, pend=0, zero_r=0, out_valid=0, in_ready=1, y=0, last=0, zero=0.
REQ-027 A reset during SCAN SHALL abandon the remaining beats; no output beat SHALL follow the reset release until a new vector is accepted.
REQ-028 The first accept after reset deassertion SHALL be possible on the first rising edge on which rst_n=1.

Structure
REQ-029 Shared package encoder_pkg SHALL hold the constants N_IN=8 and W_IDX=3 and the FSM state type (IDLE, SCAN).
REQ-030 Pure combinational priority selection SHALL be a sub-module prio_enc8 (8-bit in, 3-bit index, one-bit-left flag, direction parameter), instantiated once.
REQ-031 Total RTL, including prio_enc8, SHALL be 120-400 lines.

Verification
REQ-032 Reset then i=8'b0000_0001, in_valid pulse, out_ready=1 -> one beat y=000, last=1, zero=0; in_ready=1 the following cycle.
REQ-033 i=8'b1010_0100 with HIGH_FIRST=1, out_ready=1 -> beats y=111, 101, 010 on consecutive cycles; last=1 only on y=010.
REQ-034 Same vector with HIGH_FIRST=0 -> beats y=010, 101, 111.
REQ-035 i=8'h00 -> single beat y=000, zero=1, last=1; FSM back in IDLE after the handshake.
REQ-036 i=8'hFF with out_ready toggling 1,0,0,1,...: 8 beats y=7..0, outputs stable while stalled, and in_valid pulses during SCAN are ignored (in_ready=0).
REQ-037 Reset asserted mid-SCAN after 2 of 5 beats -> out_valid=0 immediately (asynchronous); after release, no further beats appear; a new vector 8'h10 yields one beat y=100.
REQ-038 The scoreboard SHALL compare each beat sequence against a popcount/order model for all 256 input vectors.
